// File: rtl/game_state_ctrl.sv
// Score, lives and dot bookkeeping plus IDLE/PLAY/DEATH/GAMEOVER/WIN sequencing for the maze game.
// Optional feature macro: GAME_STATE_GHOST_COMBO_EN (ghost value doubles per ghost eaten in one power period).
module game_state_ctrl #(
  parameter int START_LIVES = 3,
  parameter int TOTAL_DOTS  = 240,
  parameter int DOT_W       = 9,
  parameter int SCORE_W     = 16,
  parameter int DOT_PTS     = 10,
  parameter int PILL_PTS    = 50,
  parameter int GHOST_PTS   = 200,
  parameter int DEATH_HOLD  = 50000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               coll_valid,
  input  logic [3:0]         collision_type,
  input  logic [32:0]        pill_count,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [DOT_W-1:0]   dots_left,
  output logic [2:0]         game_state,
  output logic               power_active,
  output logic               respawn,
  output logic               ghost1_eaten,
  output logic               ghost2_eaten,
  output logic               wall_hit
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DEATH    = 3'd2,
    S_GAMEOVER = 3'd3,
    S_WIN      = 3'd4
  } state_t;

  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

  state_t      state;
  logic [31:0] death_cnt;
  logic [31:0] ghost_val;
  logic [31:0] pts;
  logic [31:0] sum;
  logic [SCORE_W-1:0] score_next;
  logic        dec, dec_ok, win, die, eat1, eat2, wall;

  assign game_state = state;

`ifdef GAME_STATE_GHOST_COMBO_EN
  logic [1:0] combo_n;
  assign ghost_val = 32'(GHOST_PTS) << combo_n;

  // Combo restarts whenever a power period ends
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      combo_n <= 2'd0;
    else if (power_active && (pill_count == '0))
      combo_n <= 2'd0;
    else if ((eat1 || eat2) && (combo_n != 2'd3))
      combo_n <= combo_n + 2'd1;
  end
`else
  assign ghost_val = 32'(GHOST_PTS);
`endif

  always_comb begin
    pts  = '0;
    dec  = 1'b0;
    die  = 1'b0;
    eat1 = 1'b0;
    eat2 = 1'b0;
    wall = 1'b0;
    if (state == S_PLAY && coll_valid) begin
      case (collision_type)
        4'b0001: wall = 1'b1;
        4'b0010: begin pts = 32'(DOT_PTS);  dec = 1'b1; end
        4'b0011: begin pts = 32'(PILL_PTS); dec = 1'b1; end
        4'b0100, 4'b0101: begin
          if (power_active) begin
            pts  = ghost_val;
            eat1 = ~collision_type[0];
            eat2 = collision_type[0];
          end else begin
            die = 1'b1;
          end
        end
        4'b0110, 4'b0111: begin
          pts  = 32'(PILL_PTS) + ghost_val;
          dec  = 1'b1;
          eat1 = ~collision_type[0];
          eat2 = collision_type[0];
        end
        4'b1000, 4'b1001: begin
          dec = 1'b1;
          if (power_active) begin
            pts  = 32'(DOT_PTS) + ghost_val;
            eat1 = ~collision_type[0];
            eat2 = collision_type[0];
          end else begin
            pts = 32'(DOT_PTS);
            die = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Sum in 32 bits so the clamp sees the overflow instead of a wrapped value
    sum        = 32'(score) + pts;
    score_next = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
    dec_ok     = dec && (dots_left != '0);
    win        = dec_ok && (dots_left == DOT_W'(1));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      score        <= '0;
      lives        <= 2'(START_LIVES);
      dots_left    <= DOT_W'(TOTAL_DOTS);
      death_cnt    <= '0;
      power_active <= 1'b0;
      respawn      <= 1'b0;
      ghost1_eaten <= 1'b0;
      ghost2_eaten <= 1'b0;
      wall_hit     <= 1'b0;
    end else begin
      power_active <= (pill_count != '0);
      respawn      <= 1'b0;
      ghost1_eaten <= 1'b0;
      ghost2_eaten <= 1'b0;
      wall_hit     <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_PLAY;
        S_PLAY: begin
          score        <= score_next;
          wall_hit     <= wall;
          ghost1_eaten <= eat1;
          ghost2_eaten <= eat2;
          if (dec_ok) dots_left <= dots_left - DOT_W'(1);
          // Clearing the last dot wins even when the same code would have killed
          if (win) begin
            state <= S_WIN;
          end else if (die) begin
            if (lives <= 2'd1) begin
              lives <= 2'd0;
              state <= S_GAMEOVER;
            end else begin
              lives     <= lives - 2'd1;
              death_cnt <= '0;
              state     <= S_DEATH;
            end
          end
        end
        S_DEATH: begin
          if (death_cnt == 32'(DEATH_HOLD - 1)) begin
            respawn   <= 1'b1;
            death_cnt <= '0;
            state     <= S_PLAY;
          end else begin
            death_cnt <= death_cnt + 32'd1;
          end
        end
        S_GAMEOVER, S_WIN: begin
          if (start) begin
            score     <= '0;
            lives     <= 2'(START_LIVES);
            dots_left <= DOT_W'(TOTAL_DOTS);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed self-checking bench for game_state_ctrl; three instances cover default, tiny-map and narrow-score builds.
module tb_game_state_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        coll_valid = 1'b0;
  logic [3:0]  collision_type = 4'd0;
  logic [32:0] pill_count = '0;

  logic [15:0] score;
  logic [1:0]  lives;
  logic [8:0]  dots_left;
  logic [2:0]  game_state;
  logic        power_active, respawn, ghost1_eaten, ghost2_eaten, wall_hit;

  logic [15:0] w_score;
  logic [1:0]  w_lives;
  logic [8:0]  w_dots;
  logic [2:0]  w_state;
  logic        w_pwr, w_resp, w_g1, w_g2, w_wall;

  logic [7:0]  s_score;
  logic [1:0]  s_lives;
  logic [8:0]  s_dots;
  logic [2:0]  s_state;
  logic        s_pwr, s_resp, s_g1, s_g2, s_wall;

  int compared = 0;
  int mismatched = 0;

`ifdef GAME_STATE_GHOST_COMBO_EN
  localparam int EXP_TWO_GHOSTS = 600;
  localparam int EXP_AFTER_COMBO_PILL = 1450;
`else
  localparam int EXP_TWO_GHOSTS = 400;
  localparam int EXP_AFTER_COMBO_PILL = 650;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  game_state_ctrl #(.DEATH_HOLD(20)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .coll_valid(coll_valid),
    .collision_type(collision_type), .pill_count(pill_count), .score(score), .lives(lives),
    .dots_left(dots_left), .game_state(game_state), .power_active(power_active),
    .respawn(respawn), .ghost1_eaten(ghost1_eaten), .ghost2_eaten(ghost2_eaten), .wall_hit(wall_hit));

  game_state_ctrl #(.TOTAL_DOTS(2), .DEATH_HOLD(20)) dut_win (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .coll_valid(coll_valid),
    .collision_type(collision_type), .pill_count(pill_count), .score(w_score), .lives(w_lives),
    .dots_left(w_dots), .game_state(w_state), .power_active(w_pwr),
    .respawn(w_resp), .ghost1_eaten(w_g1), .ghost2_eaten(w_g2), .wall_hit(w_wall));

  game_state_ctrl #(.SCORE_W(8), .DEATH_HOLD(20)) dut_sat (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .coll_valid(coll_valid),
    .collision_type(collision_type), .pill_count(pill_count), .score(s_score), .lives(s_lives),
    .dots_left(s_dots), .game_state(s_state), .power_active(s_pwr),
    .respawn(s_resp), .ghost1_eaten(s_g1), .ghost2_eaten(s_g2), .wall_hit(s_wall));

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; coll_valid = 1'b0; collision_type = 4'd0; pill_count = '0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] code);
    coll_valid = 1'b1; collision_type = code;
    @(posedge CLOCK_50); #1;
    coll_valid = 1'b0; collision_type = 4'd0;
  endtask

  task automatic wait_respawn(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLOCK_50); #1;
      if (respawn) begin cycles = i; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (game_state !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_state got %0d want 0", game_state); end
    compared++; if (score !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_score got %0d want 0", score); end
    compared++; if (lives !== 2'd3) begin mismatched++; $display("[TB] FAIL reset_lives got %0d want 3", lives); end
    compared++; if (dots_left !== 9'd240) begin mismatched++; $display("[TB] FAIL reset_dots got %0d want 240", dots_left); end
    compared++; if ({power_active, respawn, ghost1_eaten, ghost2_eaten, wall_hit} !== 5'b0) begin
      mismatched++; $display("[TB] FAIL reset_pulses got %b want 00000", {power_active, respawn, ghost1_eaten, ghost2_eaten, wall_hit}); end
  endtask

  task automatic test_dots();
    do_reset();
    strobe(4'b0010);
    compared++; if (score !== 16'd0) begin mismatched++; $display("[TB] FAIL idle_ignores got %0d want 0", score); end
    pulse_start();
    compared++; if (game_state !== 3'd1) begin mismatched++; $display("[TB] FAIL start_play got %0d want 1", game_state); end
    for (int i = 0; i < 3; i++) strobe(4'b0010);
    compared++; if (score !== 16'd30) begin mismatched++; $display("[TB] FAIL dots_score got %0d want 30", score); end
    compared++; if (dots_left !== 9'd237) begin mismatched++; $display("[TB] FAIL dots_left got %0d want 237", dots_left); end
    strobe(4'b0001);
    compared++; if (wall_hit !== 1'b1) begin mismatched++; $display("[TB] FAIL wall_pulse got %0d want 1", wall_hit); end
    @(posedge CLOCK_50); #1;
    compared++; if (wall_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL wall_clear got %0d want 0", wall_hit); end
  endtask

  task automatic test_death();
    int cyc;
    do_reset(); pulse_start();
    strobe(4'b0100);
    compared++; if (lives !== 2'd2) begin mismatched++; $display("[TB] FAIL death_lives got %0d want 2", lives); end
    compared++; if (game_state !== 3'd2) begin mismatched++; $display("[TB] FAIL death_state got %0d want 2", game_state); end
    strobe(4'b0010);
    compared++; if (score !== 16'd0) begin mismatched++; $display("[TB] FAIL death_ignores got %0d want 0", score); end
    wait_respawn(cyc);
    compared++; if (cyc !== 19) begin mismatched++; $display("[TB] FAIL respawn_delay got %0d want 19", cyc); end
    compared++; if (game_state !== 3'd1) begin mismatched++; $display("[TB] FAIL respawn_state got %0d want 1", game_state); end
    @(posedge CLOCK_50); #1;
    compared++; if (respawn !== 1'b0) begin mismatched++; $display("[TB] FAIL respawn_single got %0d want 0", respawn); end
  endtask

  task automatic test_gameover();
    int cyc;
    do_reset(); pulse_start();
    strobe(4'b0010);
    strobe(4'b0100); wait_respawn(cyc);
    strobe(4'b0101); wait_respawn(cyc);
    strobe(4'b0100);
    compared++; if (lives !== 2'd0) begin mismatched++; $display("[TB] FAIL gameover_lives got %0d want 0", lives); end
    compared++; if (game_state !== 3'd3) begin mismatched++; $display("[TB] FAIL gameover_state got %0d want 3", game_state); end
    strobe(4'b0010);
    compared++; if (score !== 16'd10) begin mismatched++; $display("[TB] FAIL gameover_frozen got %0d want 10", score); end
    pulse_start();
    compared++; if (game_state !== 3'd0) begin mismatched++; $display("[TB] FAIL restart_state got %0d want 0", game_state); end
    compared++; if ({score, lives, dots_left} !== {16'd0, 2'd3, 9'd240}) begin
      mismatched++; $display("[TB] FAIL restart_counters got %0d/%0d/%0d want 0/3/240", score, lives, dots_left); end
  endtask

  task automatic test_ghost_power();
    do_reset(); pulse_start();
    pill_count = 33'd100;
    @(posedge CLOCK_50); #1;
    compared++; if (power_active !== 1'b1) begin mismatched++; $display("[TB] FAIL power_on got %0d want 1", power_active); end
    strobe(4'b0101);
    compared++; if ({ghost1_eaten, ghost2_eaten} !== 2'b01) begin mismatched++; $display("[TB] FAIL ghost2_pulse got %b want 01", {ghost1_eaten, ghost2_eaten}); end
    compared++; if (score !== 16'd200) begin mismatched++; $display("[TB] FAIL ghost2_score got %0d want 200", score); end
    strobe(4'b0100);
    compared++; if ({ghost1_eaten, ghost2_eaten} !== 2'b10) begin mismatched++; $display("[TB] FAIL ghost1_pulse got %b want 10", {ghost1_eaten, ghost2_eaten}); end
    compared++; if (score !== 16'(EXP_TWO_GHOSTS)) begin mismatched++; $display("[TB] FAIL two_ghost_score got %0d want %0d", score, EXP_TWO_GHOSTS); end
    compared++; if (lives !== 2'd3) begin mismatched++; $display("[TB] FAIL powered_lives got %0d want 3", lives); end
    strobe(4'b0110);
    compared++; if (score !== 16'(EXP_AFTER_COMBO_PILL)) begin mismatched++; $display("[TB] FAIL ghost_pill_score got %0d want %0d", score, EXP_AFTER_COMBO_PILL); end
    compared++; if (dots_left !== 9'd239) begin mismatched++; $display("[TB] FAIL ghost_pill_dots got %0d want 239", dots_left); end
    pill_count = '0;
    @(posedge CLOCK_50); #1;
    compared++; if (power_active !== 1'b0) begin mismatched++; $display("[TB] FAIL power_off got %0d want 0", power_active); end
  endtask

  task automatic test_win();
    do_reset(); pulse_start();
    strobe(4'b0011);
    compared++; if (w_dots !== 9'd1) begin mismatched++; $display("[TB] FAIL win_dots1 got %0d want 1", w_dots); end
    strobe(4'b1000);
    compared++; if (w_dots !== 9'd0) begin mismatched++; $display("[TB] FAIL win_dots0 got %0d want 0", w_dots); end
    compared++; if (w_state !== 3'd4) begin mismatched++; $display("[TB] FAIL win_state got %0d want 4", w_state); end
    compared++; if (w_lives !== 2'd3) begin mismatched++; $display("[TB] FAIL win_lives got %0d want 3", w_lives); end
    compared++; if (w_score !== 16'd60) begin mismatched++; $display("[TB] FAIL win_score got %0d want 60", w_score); end
    strobe(4'b0010);
    compared++; if ({w_score, w_dots} !== {16'd60, 9'd0}) begin mismatched++; $display("[TB] FAIL win_frozen got %0d/%0d want 60/0", w_score, w_dots); end
    pulse_start();
    compared++; if ({w_state, w_dots} !== {3'd0, 9'd2}) begin mismatched++; $display("[TB] FAIL win_restart got %0d/%0d want 0/2", w_state, w_dots); end
  endtask

  task automatic test_saturation();
    do_reset(); pulse_start();
    for (int i = 0; i < 5; i++) strobe(4'b0011);
    compared++; if (s_score !== 8'd250) begin mismatched++; $display("[TB] FAIL sat_before got %0d want 250", s_score); end
    strobe(4'b0011);
    compared++; if (s_score !== 8'd255) begin mismatched++; $display("[TB] FAIL sat_clamp got %0d want 255", s_score); end
    strobe(4'b0011);
    compared++; if (s_score !== 8'd255) begin mismatched++; $display("[TB] FAIL sat_hold got %0d want 255", s_score); end
    strobe(4'b0100);
    compared++; if (s_state !== 3'd2) begin mismatched++; $display("[TB] FAIL sat_death got %0d want 2", s_state); end
    repeat (3) @(posedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    compared++; if ({s_state, s_score, s_lives, s_dots} !== {3'd0, 8'd0, 2'd3, 9'd240}) begin
      mismatched++; $display("[TB] FAIL async_reset got %0d/%0d/%0d/%0d want 0/0/3/240", s_state, s_score, s_lives, s_dots); end
    compared++; if ({s_pwr, s_resp, s_g1, s_g2, s_wall} !== 5'b0) begin
      mismatched++; $display("[TB] FAIL async_reset_pulses got %b want 00000", {s_pwr, s_resp, s_g1, s_g2, s_wall}); end
    @(posedge CLOCK_50); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dots();
    test_death();
    test_gameover();
    test_ghost_power();
    test_win();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
